// File: rtl/data_mem_port_pkg.sv
// Shared types and helpers for the memory-stage data-bus master.
//   mem_op_t    : access size/sign carried down the pipeline from decode
//   dbus_cmd_t  : registered bus command (we, word address, strobes, write data)
//   is_aligned  : natural-alignment check for a given op and byte offset
//   store_strb  : byte-lane strobes for a store
//   store_data  : lane-replicated store data
package data_mem_port_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [2:0] {
        MEM_NOP = 3'd0,
        MEM_B   = 3'd1,
        MEM_BU  = 3'd2,
        MEM_H   = 3'd3,
        MEM_HU  = 3'd4,
        MEM_W   = 3'd5
    } mem_op_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [STRB_W-1:0] wstrb;
        logic [XLEN-1:0]   wdata;
    } dbus_cmd_t;

    // Bytes are always aligned; halves need an even address, words a multiple of 4.
    function automatic logic is_aligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            MEM_H, MEM_HU: return ~off[0];
            MEM_W:         return (off == 2'b00);
            default:       return 1'b1;
        endcase
    endfunction

    function automatic logic [STRB_W-1:0] store_strb(input mem_op_t op, input logic [1:0] off);
        case (op)
            MEM_H, MEM_HU: return off[1] ? 4'b1100 : 4'b0011;
            MEM_W:         return 4'b1111;
            default:       return 4'(4'b0001 << off);
        endcase
    endfunction

    // The slave picks the lane via the strobes, so every lane carries the datum.
    function automatic logic [XLEN-1:0] store_data(input mem_op_t op, input logic [XLEN-1:0] d);
        case (op)
            MEM_B, MEM_BU: return {4{d[7:0]}};
            MEM_H, MEM_HU: return {2{d[15:0]}};
            default:       return d;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_port_load_extender.sv
// Combinational load-data extraction and extension.
//   op     : access size/sign of the load
//   offset : byte offset of the access within the word
//   rdata  : raw word returned by the data bus
//   result : byte/half selected and sign- or zero-extended; words passed through
module load_extender
    import data_mem_port_pkg::*;
(
    input  mem_op_t         op,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension
    always_comb begin
        result = rdata;
        case (op)
            MEM_B:   result = {{24{byte_sel[7]}}, byte_sel};
            MEM_BU:  result = {24'h0, byte_sel};
            MEM_H:   result = {{16{half_sel[15]}}, half_sel};
            MEM_HU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_port.sv
// Memory-stage data-bus master between the EX/MEM and MEM/WB registers.
//   clk, rst                  : clock, async active-high reset
//   mem_ctrl_mem              : access size/sign (MEM_NOP = no access)
//   mem_do_write_ctrl_mem     : 1 = store, 0 = load
//   alu_result_mem            : effective byte address
//   mem_data_in_mem           : store data
//   dbus_req/we/addr/wstrb/wdata : registered bus command, held until ack
//   dbus_ack, dbus_rdata      : completion pulse and read word
//   load_data_mem             : extended load result for MEM/WB
//   mem_stall                 : hold upstream pipeline registers (combinational)
//   misalign_fault            : misaligned access seen in IDLE (combinational)
module data_mem_port
    import data_mem_port_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  mem_op_t           mem_ctrl_mem,
    input  logic              mem_do_write_ctrl_mem,
    input  logic [XLEN-1:0]   alu_result_mem,
    input  logic [XLEN-1:0]   mem_data_in_mem,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [XLEN-1:0]   dbus_addr,
    output logic [STRB_W-1:0] dbus_wstrb,
    output logic [XLEN-1:0]   dbus_wdata,
    input  logic              dbus_ack,
    input  logic [XLEN-1:0]   dbus_rdata,
    output logic [XLEN-1:0]   load_data_mem,
    output logic              mem_stall,
    output logic              misalign_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    dmem_state_t     state_q, state_d;
    dbus_cmd_t       cmd_q, cmd_d;
    logic            req_q, req_d;
    logic [1:0]      off_q, off_d;
    mem_op_t         op_q, op_d;
    logic [XLEN-1:0] load_q, load_d;
    logic [XLEN-1:0] ext_data;
    logic            aligned;

    // Extension of the returned word, used only on the ack-capture path
    load_extender u_load_extender (
        .op     (op_q),
        .offset (off_q),
        .rdata  (dbus_rdata),
        .result (ext_data)
    );

    // Next-state, next-output and combinational handshake outputs
    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        req_d          = req_q;
        off_d          = off_q;
        op_d           = op_q;
        load_d         = load_q;
        mem_stall      = 1'b0;
        misalign_fault = 1'b0;
        aligned        = is_aligned(mem_ctrl_mem, alu_result_mem[1:0]);

        case (state_q)
            IDLE: begin
                if (mem_ctrl_mem != MEM_NOP) begin
                    if (aligned) begin
                        cmd_d.we    = mem_do_write_ctrl_mem;
                        cmd_d.addr  = {alu_result_mem[XLEN-1:2], 2'b00};
                        cmd_d.wstrb = mem_do_write_ctrl_mem
                                    ? store_strb(mem_ctrl_mem, alu_result_mem[1:0])
                                    : '0;
                        cmd_d.wdata = store_data(mem_ctrl_mem, mem_data_in_mem);
                        off_d       = alu_result_mem[1:0];
                        op_d        = mem_ctrl_mem;
                        req_d       = 1'b1;
                        mem_stall   = 1'b1;
                        state_d     = BUSY;
                    end else begin
                        // Dropped on the floor: no request, pipeline keeps moving
                        misalign_fault = 1'b1;
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dbus_ack) begin
                    req_d       = 1'b0;
                    cmd_d.we    = 1'b0;
                    cmd_d.wstrb = '0;
                    if (!cmd_q.we) begin
                        load_d = ext_data;
                    end
                    state_d = DONE;
                end
            end
            // Inputs still show the finished instruction here; skip them so it is not re-issued
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            req_q   <= 1'b0;
            off_q   <= 2'b00;
            op_q    <= MEM_NOP;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            req_q   <= req_d;
            off_q   <= off_d;
            op_q    <= op_d;
            load_q  <= load_d;
        end
    end

    assign dbus_req      = req_q;
    assign dbus_we       = cmd_q.we;
    assign dbus_addr     = cmd_q.addr;
    assign dbus_wstrb    = cmd_q.wstrb;
    assign dbus_wdata    = cmd_q.wdata;
    assign load_data_mem = load_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: directed table, hand sequences, and
// randomized accesses checked against a behavioural model of the access rules.
module tb_data_mem_port;
    import data_mem_port_pkg::*;

    logic        clk;
    logic        rst;
    mem_op_t     mem_ctrl_mem;
    logic        mem_do_write_ctrl_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] mem_data_in_mem;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic [31:0] load_data_mem;
    logic        mem_stall;
    logic        misalign_fault;

    int          checks;
    int          errors;
    logic [31:0] model_ld;

    data_mem_port dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_ctrl_mem          (mem_ctrl_mem),
        .mem_do_write_ctrl_mem (mem_do_write_ctrl_mem),
        .alu_result_mem        (alu_result_mem),
        .mem_data_in_mem       (mem_data_in_mem),
        .dbus_req              (dbus_req),
        .dbus_we               (dbus_we),
        .dbus_addr             (dbus_addr),
        .dbus_wstrb            (dbus_wstrb),
        .dbus_wdata            (dbus_wdata),
        .dbus_ack              (dbus_ack),
        .dbus_rdata            (dbus_rdata),
        .load_data_mem         (load_data_mem),
        .mem_stall             (mem_stall),
        .misalign_fault        (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        mem_op_t     op;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---- behavioural model of the access rules ----
    function automatic logic model_misaligned(input mem_op_t op, input logic [31:0] a);
        if (op == MEM_H || op == MEM_HU) return (a % 2) != 0;
        if (op == MEM_W) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strb(input mem_op_t op, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (op == MEM_W) return 4'hF;
        if (op == MEM_H || op == MEM_HU) return 4'(3 << (off & 2));
        return 4'(1 << off);
    endfunction

    function automatic logic [31:0] model_wdata(input mem_op_t op, input logic [31:0] d);
        if (op == MEM_W) return d;
        if (op == MEM_H || op == MEM_HU) return (d & 32'hFFFF) * 32'h0001_0001;
        return (d & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] model_load(input mem_op_t op, input logic [31:0] a, input logic [31:0] rd);
        int unsigned off;
        logic [31:0] v;
        off = a % 4;
        case (op)
            MEM_B, MEM_BU: begin
                v = (rd >> (8 * off)) & 32'hFF;
                if (op == MEM_B && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            MEM_H, MEM_HU: begin
                v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                if (op == MEM_H && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Issue one access from IDLE (called at posedge+1) and check it end to end.
    task automatic run_access(input mem_op_t op, input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input int waits, input logic [31:0] rdata,
                              input logic exp_fault, input logic [31:0] e_addr,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [31:0] e_load);
        int stalls;
        mem_ctrl_mem          = op;
        mem_do_write_ctrl_mem = we;
        alu_result_mem        = addr;
        mem_data_in_mem       = data;
        @(negedge clk);
        chk("misalign_fault", 32'(misalign_fault), 32'(exp_fault));
        chk("idle_req", 32'(dbus_req), 32'd0);
        if (exp_fault) begin
            chk("fault_stall", 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            chk("fault_no_req", 32'(dbus_req), 32'd0);
            chk("fault_load_kept", load_data_mem, model_ld);
            mem_ctrl_mem = MEM_NOP;
            return;
        end
        stalls = mem_stall ? 1 : 0;
        @(posedge clk); #1;
        for (int w = 0; w <= waits; w++) begin
            dbus_ack   = (w == waits);
            dbus_rdata = (w == waits) ? rdata : $urandom;
            @(negedge clk);
            chk("busy_req", 32'(dbus_req), 32'd1);
            chk("busy_addr", dbus_addr, e_addr);
            chk("busy_we", 32'(dbus_we), 32'(we));
            chk("busy_wstrb", 32'(dbus_wstrb), 32'(e_strb));
            if (we) chk("busy_wdata", dbus_wdata, e_wdata);
            stalls += mem_stall ? 1 : 0;
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("done_req", 32'(dbus_req), 32'd0);
        chk("done_stall", 32'(mem_stall), 32'd0);
        if (!we) model_ld = e_load;
        chk("load_data", load_data_mem, model_ld);
        chk("stall_cycles", 32'(stalls), 32'(waits + 2));
        @(posedge clk); #1;
        mem_ctrl_mem = MEM_NOP;
    endtask

    initial begin
        mem_op_t     op;
        logic        we;
        logic [31:0] a, d, rd;
        logic        mis;
        logic [5:0]  pat;
        int          nreq;
        logic        prev_req;

        checks = 0;
        errors = 0;
        model_ld = 32'h0;
        rst = 1'b1;
        mem_ctrl_mem = MEM_NOP;
        mem_do_write_ctrl_mem = 1'b0;
        alu_result_mem = 32'h0;
        mem_data_in_mem = 32'h0;
        dbus_ack = 1'b0;
        dbus_rdata = 32'h0;

        // Reset values
        #12;
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_we", 32'(dbus_we), 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_wstrb", 32'(dbus_wstrb), 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        chk("rst_load", load_data_mem, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_fault", 32'(misalign_fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // NOP in IDLE: no request, no stall
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("nop_req", 32'(dbus_req), 32'd0);
            chk("nop_stall", 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
        end

        // Directed table
        tbl[0]  = '{MEM_W,  1'b0, 32'h100, 32'h0,        2, 32'hDEADBEEF, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{MEM_B,  1'b0, 32'h103, 32'h0,        0, 32'h80FF0000, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{MEM_BU, 1'b0, 32'h103, 32'h0,        0, 32'h80FF0000, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00000080};
        tbl[3]  = '{MEM_H,  1'b1, 32'h206, 32'h1234ABCD, 0, 32'h0,        1'b0, 32'h204, 4'b1100, 32'hABCDABCD, 32'h0};
        tbl[4]  = '{MEM_W,  1'b1, 32'h302, 32'h11223344, 0, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        tbl[5]  = '{MEM_H,  1'b0, 32'h202, 32'h0,        1, 32'h80017FFF, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFF8001};
        tbl[6]  = '{MEM_HU, 1'b0, 32'h200, 32'h0,        0, 32'h8001F00F, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h0000F00F};
        tbl[7]  = '{MEM_B,  1'b1, 32'h001, 32'h00000055, 0, 32'h0,        1'b0, 32'h000, 4'b0010, 32'h55555555, 32'h0};
        tbl[8]  = '{MEM_H,  1'b0, 32'h101, 32'h0,        0, 32'hFFFFFFFF, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
        tbl[9]  = '{MEM_W,  1'b1, 32'h040, 32'hCAFEF00D, 3, 32'h0,        1'b0, 32'h040, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[10] = '{MEM_B,  1'b0, 32'h000, 32'h0,        0, 32'h0000007F, 1'b0, 32'h000, 4'b0000, 32'h0,        32'h0000007F};
        for (int i = 0; i < 11; i++) begin
            run_access(tbl[i].op, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].waits, tbl[i].rdata,
                       tbl[i].fault, tbl[i].e_addr, tbl[i].e_strb, tbl[i].e_wdata, tbl[i].e_load);
        end

        // Back-to-back word loads with immediate acks
        pat = '0;
        nreq = 0;
        prev_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin
                    mem_ctrl_mem = MEM_W; mem_do_write_ctrl_mem = 1'b0; alu_result_mem = 32'h10;
                end
                1: begin dbus_ack = 1'b1; dbus_rdata = 32'hA5A5_0001; end
                2: dbus_ack = 1'b0;
                3: alu_result_mem = 32'h14;
                4: begin dbus_ack = 1'b1; dbus_rdata = 32'h5A5A_0002; end
                default: dbus_ack = 1'b0;
            endcase
            @(negedge clk);
            pat[5-c] = mem_stall;
            if (dbus_req && !prev_req) nreq++;
            prev_req = dbus_req;
            if (c == 2) chk("b2b_load0", load_data_mem, 32'hA5A5_0001);
            if (c == 5) chk("b2b_load1", load_data_mem, 32'h5A5A_0002);
            @(posedge clk); #1;
        end
        mem_ctrl_mem = MEM_NOP;
        model_ld = 32'h5A5A_0002;
        chk("b2b_stall_pattern", 32'(pat), 32'h36);
        chk("b2b_request_count", 32'(nreq), 32'd2);

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            op = mem_op_t'(3'($urandom_range(1, 5)));
            we = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            rd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op == MEM_H || op == MEM_HU) a[0] = 1'b0;
                if (op == MEM_W) a[1:0] = 2'b00;
            end
            mis = model_misaligned(op, a);
            run_access(op, we, a, d, $urandom_range(0, 3), rd, mis, a & 32'hFFFF_FFFC,
                       we ? model_strb(op, a) : 4'b0000, model_wdata(op, d),
                       model_load(op, a, rd));
        end

        // Async reset in BUSY, then a late ack
        mem_ctrl_mem = MEM_W; mem_do_write_ctrl_mem = 1'b0; alu_result_mem = 32'h80;
        @(negedge clk);
        chk("pre_rst_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", 32'(dbus_req), 32'd1);
        #2;
        rst = 1'b1;
        mem_ctrl_mem = MEM_NOP;
        #1;
        chk("rst_busy_req", 32'(dbus_req), 32'd0);
        chk("rst_busy_stall", 32'(mem_stall), 32'd0);
        model_ld = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("late_ack_req", 32'(dbus_req), 32'd0);
        chk("late_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_load", load_data_mem, 32'h0);
        @(posedge clk); #1;

        // Recovery after reset
        run_access(MEM_HU, 1'b0, 32'h0000_0C02, 32'h0, 1, 32'hBEEF_1234, 1'b0,
                   32'h0000_0C00, 4'b0000, 32'h0, 32'h0000_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Memory-stage data-bus master that consumes the EX/MEM register outputs and performs the actual load/store on the external data bus using a req/ack handshake. It converts byte/half/word accesses into word-aligned bus transactions with byte strobes, sign/zero-extends load data for MEM/WB, and raises a stall to the hazard unit while a transaction is outstanding. Sits between the EX/MEM and MEM/WB registers; `mem_stall` drives the `enable`-low path of upstream pipeline registers.

## Interface
- No parameters (32-bit data, 32-bit address fixed).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_ctrl_mem` in `mem_op_t`: access size/sign (`MEM_NOP`, `MEM_B`, `MEM_BU`, `MEM_H`, `MEM_HU`, `MEM_W`).
- `mem_do_write_ctrl_mem` in 1: 1 = store, 0 = load; ignored when `MEM_NOP`.
- `alu_result_mem` in 32: effective byte address.
- `mem_data_in_mem` in 32: store data (low bits significant).
- `dbus_req` out 1: transaction request, held until ack.
- `dbus_we` out 1: write enable.
- `dbus_addr` out 32: word address, `[1:0]` always 0.
- `dbus_wstrb` out 4: byte strobes; 0000 for loads.
- `dbus_wdata` out 32: lane-replicated store data.
- `dbus_ack` in 1: one-cycle completion pulse.
- `dbus_rdata` in 32: read word, valid with `dbus_ack`.
- `load_data_mem` out 32: extended load result to MEM/WB.
- `mem_stall` out 1: hold upstream pipeline registers.
- `misalign_fault` out 1: misaligned access detected this cycle.

## Operation
- FSM states `IDLE`, `BUSY`, `DONE`; reset → `IDLE`.
- Access valid = `mem_ctrl_mem != MEM_NOP` and aligned. Aligned: byte always; half `addr[0]==0`; word `addr[1:0]==0`.
- `IDLE`, valid access: register `dbus_addr={addr[31:2],2'b00}`, `dbus_we`, `dbus_wstrb`, `dbus_wdata`, byte offset, op; set `dbus_req`; → `BUSY`.
- `IDLE`, NOP: stay; no request.
- `IDLE`, misaligned: `misalign_fault`=1 (combinational); no request, no stall, store suppressed, `load_data_mem` unchanged; stay `IDLE`.
- `BUSY`: hold all bus outputs stable until `dbus_ack`. On ack: clear `dbus_req`; for loads capture extended `dbus_rdata` into `load_data_mem`; → `DONE`.
- `DONE`: unconditionally → `IDLE`; inputs not examined (prevents re-issuing the same instruction).
- `mem_stall` = (`IDLE` & valid access) | `BUSY`. Low in `DONE`, so the pipeline advances exactly once per access.
- Store lanes: `B`: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]. `H`: wdata={2{d[15:0]}}, wstrb=0011<<(2*addr[1]). `W`: wdata=d, wstrb=1111.
- Load extract: byte at bits `8*off+:8`, half at `16*off[1]+:16`; `B`/`H` sign-extend, `BU`/`HU` zero-extend, `W` raw.
- Stores leave `load_data_mem` unchanged.
- `dbus_ack` outside `BUSY` is ignored.

## Timing
- Reset values: `dbus_req`=0, `dbus_we`=0, `dbus_addr`=0, `dbus_wstrb`=0, `dbus_wdata`=0, `load_data_mem`=0; `mem_stall`, `misalign_fault` = 0 (state `IDLE`, op `MEM_NOP`).
- `dbus_req` rises one cycle after the access appears in `IDLE`; ack in the first `BUSY` cycle gives a 3-cycle access (`IDLE`, `BUSY`, `DONE`); each extra wait cycle adds one.
- `load_data_mem` valid from the `DONE` cycle onward; MEM/WB captures it at the end of `DONE`.
- Async `rst` mid-transaction: immediate return to `IDLE`, `dbus_req` drops without waiting for ack; a late ack is ignored.
- Back-to-back accesses: next instruction is seen in the cycle after `DONE`; no bubble beyond `DONE`.

## Structure
- `control_types.sv`: add `MEM_B`, `MEM_BU`, `MEM_H`, `MEM_HU`, `MEM_W` to `mem_op_t` alongside `MEM_NOP`.
- FSM state enum `dmem_state_t` stays local to the module.
- One sub-module: `load_extender` (combinational; op, offset, rdata → 32-bit result), instantiated on the ack-capture path.

## Test plan
- Reset mid-`BUSY` with `dbus_req`=1 → next edge `dbus_req`=0, `mem_stall`=0, state `IDLE`; a later ack causes no output change.
- `MEM_W` load at 0x100, ack after 2 wait cycles with rdata=0xDEADBEEF → `dbus_addr`=0x100, `dbus_wstrb`=0000, stall high 4 cycles, `load_data_mem`=0xDEADBEEF.
- `MEM_B` load at 0x103, rdata=0x80FF_0000 → 0xFFFFFF80; same with `MEM_BU` → 0x00000080.
- `MEM_H` store at 0x206, data 0x1234ABCD → `dbus_addr`=0x204, `dbus_wstrb`=1100, `dbus_wdata`=0xABCDABCD, `dbus_we`=1.
- `MEM_W` store at 0x302 → `misalign_fault`=1, `dbus_req` stays 0, `mem_stall`=0.
- Two consecutive `MEM_W` loads with immediate acks → exactly two requests, stall pattern 1,1,0,1,1,0.
